// File: rtl/student_video_pkg.sv
// Shared constants, stage bundle and helpers for the luma pixel processor.
// Mode codes, address slicing and the stage-1 register bundle.
package student_video_pkg;

  localparam logic [1:0] MODE_BYPASS = 2'b00;
  localparam logic [1:0] MODE_BIN    = 2'b01;
  localparam logic [1:0] MODE_INV    = 2'b10;
  localparam logic [1:0] MODE_GRAD   = 2'b11;

  localparam int LINE_PIX  = 702;
  localparam int LATENCY   = 2;

  localparam int COL_LSB   = 0;
  localparam int COL_W     = 10;
  localparam int FIELD_BIT = 10;
  localparam int ROW_LSB   = 11;
  localparam int ROW_W     = 9;
  localparam int LID_W     = ROW_W + 1;

  typedef struct packed {
    logic [7:0]       pix;
    logic [7:0]       prev;
    logic [COL_W-1:0] col;
    logic             first;
  } s1_t;

  // |a - b| formed through a 9-bit signed difference
  function automatic logic [7:0] abs_diff(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic signed [8:0] d;
    logic signed [8:0] n;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    n = -d;
    return d[8] ? n[7:0] : d[7:0];
  endfunction

endpackage

// File: rtl/student_block_core_pixel_op.sv
// Combinational per-pixel operator.
// Selects bypass, binarize, invert or gradient on one luma byte.
module pixel_op
  import student_video_pkg::*;
#(
  parameter int THRESHOLD = 128
) (
  input  logic [1:0] i_mode,
  input  logic [7:0] i_pixel,
  input  logic [7:0] i_prev,
  input  logic       i_first,
  output logic [7:0] o_result
);

  logic       w_hi;
  logic [7:0] w_grad;

  assign w_hi   = 32'(i_pixel) >= THRESHOLD;
  assign w_grad = i_first ? 8'h00
                          : abs_diff(i_pixel, i_prev);

  // mode decode onto the result byte
  always_comb begin
    o_result = i_pixel;
    unique case (1'b1)
      (i_mode == MODE_BYPASS): o_result = i_pixel;
      (i_mode == MODE_BIN):    o_result = w_hi ? 8'hFF : 8'h00;
      (i_mode == MODE_INV):    o_result = 8'hFF - i_pixel;
      (i_mode == MODE_GRAD):   o_result = w_grad;
      default:                 o_result = i_pixel;
    endcase
  end

endmodule

// File: rtl/student_block_core.sv
// Two-stage per-pixel processor for interlaced 8-bit luma video.
// One output strobe per accepted input strobe, two clocks later.
module student_block_core
  import student_video_pkg::*;
#(
  parameter int THRESHOLD = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        video_frame_valid,
  input  logic        video_line_valid,
  input  logic        video_data_valid,
  input  logic [7:0]  video_data_in,
  input  logic [19:0] video_address,
  output logic        video_data_ready,
  output logic [7:0]  video_data_out
);

  logic             r_fv_q;
  logic             r_lv_q;
  logic [1:0]       r_mode_q;
  logic [7:0]       r_prev;
  logic [LID_W-1:0] r_prev_line;
  logic             r_first_pend;
  s1_t              r_s1;
  logic             r_s1_vld;
  logic             r_s2_vld;
  logic [7:0]       r_out;

  logic             w_accept;
  logic             w_fv_rise;
  logic             w_lv_rise;
  logic [COL_W-1:0] w_col;
  logic [LID_W-1:0] w_line_id;
  logic             w_first;
  logic             w_s2_first;
  logic [7:0]       w_result;

  assign w_accept  = video_data_valid
                   & video_frame_valid
                   & video_line_valid;
  assign w_fv_rise = video_frame_valid & ~r_fv_q;
  assign w_lv_rise = video_line_valid & ~r_lv_q;
  assign w_col     = video_address[COL_LSB +: COL_W];
  assign w_line_id = video_address[FIELD_BIT +: LID_W];

  // a new line is seen on a line_valid rise or a row/field change
  assign w_first = r_first_pend
                 | w_lv_rise
                 | (w_line_id != r_prev_line);

  // edge detectors and per-field mode latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fv_q   <= 1'b0;
      r_lv_q   <= 1'b0;
      r_mode_q <= MODE_BYPASS;
    end else begin
      r_fv_q <= video_frame_valid;
      r_lv_q <= video_line_valid;
      if (w_fv_rise) begin
        r_mode_q <= mode;
      end
    end
  end

  // remember a line start until the first pixel of that line arrives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_pend <= 1'b0;
    end else if (w_accept) begin
      r_first_pend <= 1'b0;
    end else if (w_lv_rise) begin
      r_first_pend <= 1'b1;
    end
  end

  // previous accepted pixel and the line it came from
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= 8'h00;
      r_prev_line <= '0;
    end else if (w_accept) begin
      r_prev      <= video_data_in;
      r_prev_line <= w_line_id;
    end
  end

  // stage 1: capture pixel, its predecessor, column and line-start flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1.pix   <= video_data_in;
        r_s1.prev  <= r_prev;
        r_s1.col   <= w_col;
        r_s1.first <= w_first;
      end
    end
  end

  assign w_s2_first = r_s1.first | (r_s1.col == '0);

  pixel_op #(
    .THRESHOLD (THRESHOLD)
  ) u_op (
    .i_mode   (r_mode_q),
    .i_pixel  (r_s1.pix),
    .i_prev   (r_s1.prev),
    .i_first  (w_s2_first),
    .o_result (w_result)
  );

  // stage 2: register result; data holds until the next result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0;
      r_out    <= 8'h00;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_out <= w_result;
      end
    end
  end

  assign video_data_ready = r_s2_vld;
  assign video_data_out   = r_out;

endmodule

// File: tb/tb_student_block_core.sv
// Directed self-checking bench for student_block_core.
// Inputs change on falling edges; outputs are sampled on falling edges.
module tb_student_block_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        fv;
  logic        lv;
  logic        dv;
  logic [7:0]  din;
  logic [19:0] addr;
  logic        ready;
  logic [7:0]  dout;

  int checks = 0;
  int failures = 0;
  int ready_cnt = 0;

  logic [8:0] row;
  logic       field;

  localparam int LINE = 702;

  student_block_core dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mode              (mode),
    .video_frame_valid (fv),
    .video_line_valid  (lv),
    .video_data_valid  (dv),
    .video_data_in     (din),
    .video_address     (addr),
    .video_data_ready  (ready),
    .video_data_out    (dout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ready === 1'b1) ready_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic start_field(input logic [1:0] m);
    @(negedge clk);
    fv = 1'b0;
    lv = 1'b0;
    mode = m;
    repeat (2) @(negedge clk);
    fv = 1'b1;
    @(negedge clk);
  endtask

  task automatic line_on();
    lv = 1'b1;
    @(negedge clk);
  endtask

  task automatic line_off();
    lv = 1'b0;
    @(negedge clk);
  endtask

  // one strobe; ready must appear exactly two clocks later
  task automatic send(input string tag,
                      input logic [7:0] pix,
                      input logic [9:0] col,
                      input logic [7:0] exp);
    din = pix;
    addr = {row, field, col};
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    chk({tag, "_early"}, 32'(ready), 32'd0);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(ready), 32'd1);
    chk({tag, "_out"}, 32'(dout), 32'(exp));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(ready), 32'd0);
  endtask

  initial begin
    int c0;
    int errs;
    logic [7:0] o0;
    logic [7:0] px;

    rst_n = 1'b0;
    mode = 2'b00;
    fv = 1'b0;
    lv = 1'b0;
    dv = 1'b0;
    din = 8'h00;
    addr = '0;
    row = '0;
    field = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_out", 32'(dout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out", 32'(dout), 32'd0);

    // bypass
    start_field(2'b00);
    line_on();
    send("byp0", 8'h00, 10'd0, 8'h00);
    send("byp1", 8'h7F, 10'd1, 8'h7F);
    send("byp2", 8'hFF, 10'd2, 8'hFF);

    // binarize
    start_field(2'b01);
    line_on();
    send("bin127", 8'd127, 10'd0, 8'h00);
    send("bin128", 8'd128, 10'd1, 8'hFF);
    send("bin255", 8'd255, 10'd2, 8'hFF);
    send("bin0", 8'd0, 10'd3, 8'h00);

    // invert
    start_field(2'b10);
    line_on();
    send("inv00", 8'h00, 10'd0, 8'hFF);
    send("inv5A", 8'h5A, 10'd1, 8'hA5);
    send("invFF", 8'hFF, 10'd2, 8'h00);

    // gradient
    start_field(2'b11);
    line_on();
    send("grd10", 8'd10, 10'd0, 8'd0);
    send("grd30", 8'd30, 10'd1, 8'd20);
    send("grd25", 8'd25, 10'd2, 8'd5);
    send("grd25b", 8'd25, 10'd3, 8'd0);
    line_off();
    row = row + 9'd1;
    line_on();
    send("grd_nl200", 8'd200, 10'd0, 8'd0);
    send("grd_nl50", 8'd50, 10'd1, 8'd150);
    line_off();
    line_on();
    send("grd_lrise", 8'd90, 10'd7, 8'd0);
    send("grd_after", 8'd100, 10'd8, 8'd10);

    // back-to-back gradient at full rate
    line_off();
    row = row + 9'd1;
    line_on();
    dv = 1'b1;
    din = 8'd40;
    addr = {row, field, 10'd0};
    @(negedge clk);
    din = 8'd100;
    addr = {row, field, 10'd1};
    @(negedge clk);
    chk("b2b0_rdy", 32'(ready), 32'd1);
    chk("b2b0_out", 32'(dout), 32'd0);
    din = 8'd60;
    addr = {row, field, 10'd2};
    @(negedge clk);
    dv = 1'b0;
    chk("b2b1_rdy", 32'(ready), 32'd1);
    chk("b2b1_out", 32'(dout), 32'd60);
    @(negedge clk);
    chk("b2b2_rdy", 32'(ready), 32'd1);
    chk("b2b2_out", 32'(dout), 32'd40);
    @(negedge clk);
    chk("b2b_end", 32'(ready), 32'd0);

    // strobes outside an active line or field are ignored
    line_off();
    c0 = ready_cnt;
    o0 = dout;
    din = 8'h42;
    addr = {row, field, 10'd3};
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign_lv_cnt", 32'(ready_cnt - c0), 32'd0);
    chk("ign_lv_out", 32'(dout), 32'(o0));
    lv = 1'b1;
    fv = 1'b0;
    @(negedge clk);
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    repeat (3) @(negedge clk);
    chk("ign_fv_cnt", 32'(ready_cnt - c0), 32'd0);
    chk("ign_fv_out", 32'(dout), 32'(o0));

    // mode change mid-field waits for the next field
    row = '0;
    start_field(2'b00);
    line_on();
    send("mc_byp", 8'h33, 10'd0, 8'h33);
    mode = 2'b10;
    send("mc_hold", 8'h34, 10'd1, 8'h34);
    start_field(2'b10);
    line_on();
    send("mc_inv", 8'h33, 10'd0, 8'hCC);

    // frame_valid falls with a pixel in flight
    din = 8'h6E;
    addr = {row, field, 10'd3};
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    fv = 1'b0;
    lv = 1'b0;
    @(negedge clk);
    chk("fdrop_rdy", 32'(ready), 32'd1);
    chk("fdrop_out", 32'(dout), 32'h91);

    // regression: one line per field in bypass, incl. cols past 701
    start_field(2'b00);
    c0 = ready_cnt;
    errs = 0;
    for (int f = 0; f < 2; f++) begin
      field = f[0];
      row = 9'(100 + f);
      line_on();
      for (int i = 0; i < LINE; i++) begin
        px = 8'(i * 37 + 11 + f);
        din = px;
        addr = {row, field, 10'(i)};
        dv = 1'b1;
        @(negedge clk);
        dv = 1'b0;
        @(negedge clk);
        if (!(ready === 1'b1 && dout === px)) errs++;
        repeat (6) @(negedge clk);
      end
      line_off();
    end
    repeat (3) @(negedge clk);
    chk("reg_bytes", 32'(errs), 32'd0);
    chk("reg_count", 32'(ready_cnt - c0), 32'(2 * LINE));
    line_on();
    send("col702", 8'hA1, 10'd702, 8'hA1);
    send("col703", 8'hB2, 10'd703, 8'hB2);

    // reset mid-pipeline drops the in-flight pixel
    c0 = ready_cnt;
    din = 8'h5C;
    addr = {row, field, 10'd4};
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_out0", 32'(dout), 32'd0);
    repeat (3) @(negedge clk);
    chk("mrst_cnt", 32'(ready_cnt - c0), 32'd0);
    chk("mrst_out1", 32'(dout), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst_idle_rdy", 32'(ready), 32'd0);
    chk("mrst_idle_out", 32'(dout), 32'd0);
    send("mrst_next", 8'h77, 10'd5, 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

endmodule
